// File: rtl/abc_accum.sv
// Frame accumulator behind the A*B+C pipeline: realigns the valid strobe with DATA,
// sums N valid results per frame and holds each frame sum in a valid/ready output register.
module abc_accum #(
  parameter int LATENCY = 3,
  parameter int N       = 4,
  parameter int SUM_W   = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [15:0]      data_in,
  input  logic             clear,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum,
  output logic             out_valid,
  output logic             overrun,
  output logic             busy
);

  localparam int DATA_W = 16;
  localparam int CNT_W  = $clog2(N);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t             state, state_nxt;
  logic [LATENCY-1:0] vpipe;
  logic               sample_v;
  logic [CNT_W-1:0]   cnt;
  logic [SUM_W-1:0]   acc;
  logic [SUM_W-1:0]   frame_val;
  logic               complete;
  logic               accept;
  logic               load_out;

  function automatic logic [SUM_W-1:0] widen_add(input logic [SUM_W-1:0] a,
                                                 input logic [DATA_W-1:0] d);
    return a + SUM_W'(d);
  endfunction

  assign sample_v  = vpipe[LATENCY-1];
  assign complete  = (state == ACCUM) & sample_v & (cnt == CNT_W'(N - 1));
  assign frame_val = widen_add(acc, data_in);
  assign accept    = out_valid & out_ready;
  // A completing frame may take the output register if it is empty or being emptied now.
  assign load_out  = complete & (~out_valid | out_ready);
  assign busy      = (state == ACCUM) | (|vpipe);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_v) state_nxt = ACCUM;
      ACCUM:   if (complete) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Stage: valid delay line aligning in_valid with upstream DATA
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
    end else if (clear) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  // Stage: frame accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample_v) begin
      if (complete) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= frame_val;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Stage: output register with backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (clear) begin
      sum       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (load_out) begin
      sum       <= frame_val;
      out_valid <= 1'b1;
    end else begin
      if (complete) overrun   <= 1'b1;
      if (accept)   out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_abc_accum.sv
// Bench for abc_accum: behavioural A*B+C upstream pipeline, frame vector table with a
// scoreboard queue, and hand-written reset, backpressure and clear sequences.
module tb_abc_accum;

  localparam int LATENCY = 3;
  localparam int N       = 4;
  localparam int SUM_W   = 18;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [15:0]      data_in;
  logic             clear;
  logic             out_ready;
  logic [SUM_W-1:0] sum;
  logic             out_valid;
  logic             overrun;
  logic             busy;

  logic [15:0] ua, ub, uc;
  logic [15:0] up_p0, up_p1, up_p2;

  int checks   = 0;
  int failures = 0;

  logic             s_ov, s_ovr, s_busy;
  logic [SUM_W-1:0] s_sum;
  logic             prev_ov  = 1'b0;
  logic             prev_rdy = 1'b0;
  logic             sb_en    = 1'b0;
  logic [SUM_W-1:0] exp_q[$];

  typedef struct packed {
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [3:0][15:0] c;
    logic [7:0]       gap;
    logic [17:0]      exp;
  } vec_t;

  vec_t tbl[6];

  abc_accum #(.LATENCY(LATENCY), .N(N), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
    .clear(clear), .out_ready(out_ready), .sum(sum), .out_valid(out_valid),
    .overrun(overrun), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream A*B+C model, three register stages, 16-bit unsigned result
  always @(posedge clk) begin
    up_p0 <= ua * ub + uc;
    up_p1 <= up_p0;
    up_p2 <= up_p1;
  end
  assign data_in = up_p2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // One clock cycle: drive inputs, sample outputs at the falling edge, run the scoreboard.
  task automatic cyc(input logic iv, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] c, input logic clr, input logic rdy);
    logic [SUM_W-1:0] e;
    in_valid  = iv;
    ua        = a;
    ub        = b;
    uc        = c;
    clear     = clr;
    out_ready = rdy;
    @(negedge clk);
    s_ov   = out_valid;
    s_sum  = sum;
    s_ovr  = overrun;
    s_busy = busy;
    if (sb_en && out_valid && (!prev_ov || prev_rdy)) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_out", 32'(out_valid), 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_sum", 32'(sum), 32'(e));
        chk("sb_overrun", 32'(overrun), 0);
      end
    end
    prev_ov  = out_valid;
    prev_rdy = out_ready;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                              input logic [7:0] gap, input logic [17:0] exp);
    vec_t v;
    v.a = a; v.b = b; v.c = c; v.gap = gap; v.exp = exp;
    return v;
  endfunction

  initial begin
    tbl[0] = mk({4{16'd2}}, {4{16'd3}}, {4{16'd1}}, 8'd0, 18'd28);
    tbl[1] = mk({4{16'hFFFF}}, {4{16'd1}}, {4{16'd0}}, 8'd0, 18'h3FFFC);
    tbl[2] = mk({4{16'hFFFF}}, {4{16'd1}}, {4{16'd0}}, 8'd2, 18'h3FFFC);
    tbl[3] = mk({16'd4, 16'd3, 16'd2, 16'd1}, {16'd40, 16'd30, 16'd20, 16'd10},
                {16'd3, 16'd2, 16'd1, 16'd0}, 8'd1, 18'd306);
    tbl[4] = mk({4{16'd300}}, {4{16'd200}}, {4{16'd7}}, 8'd0, 18'd240028);
    tbl[5] = mk({4{16'd0}}, {4{16'd0}}, {16'd100, 16'd1, 16'hFFFF, 16'd0}, 8'd3, 18'd65636);

    // Reset held with random inputs
    rst_n = 1'b0;
    repeat (6) cyc(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   1'($urandom), 1'($urandom));
    chk("rst_hold_out_valid", 32'(s_ov), 0);
    chk("rst_hold_sum", 32'(s_sum), 0);
    chk("rst_hold_overrun", 32'(s_ovr), 0);
    chk("rst_hold_busy", 32'(s_busy), 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_rel_out_valid", 32'(s_ov), 0);
    chk("rst_rel_sum", 32'(s_sum), 0);
    chk("rst_rel_overrun", 32'(s_ovr), 0);
    chk("rst_rel_busy", 32'(s_busy), 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 1);

    // Basic frame: A=2,B=3,C=1 on cycles 0..3
    for (int t = 0; t < 11; t++) begin
      cyc(t < 4, 16'd2, 16'd3, 16'd1, 0, 1);
      chk($sformatf("basic_out_valid_c%0d", t), 32'(s_ov), 32'(t == 7));
      if (t == 7) chk("basic_sum", 32'(s_sum), 28);
      if (t == 1) chk("basic_busy_c1", 32'(s_busy), 1);
    end

    // Vector table through the scoreboard, frames contiguous
    sb_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) begin
        if (i == N - 1) exp_q.push_back(tbl[k].exp);
        cyc(1, tbl[k].a[i], tbl[k].b[i], tbl[k].c[i], 0, 1);
        repeat (int'(tbl[k].gap)) cyc(0, 0, 0, 0, 0, 1);
      end
    end
    repeat (10) cyc(0, 0, 0, 0, 0, 1);
    sb_en = 1'b0;
    chk("sb_drain", exp_q.size(), 0);
    chk("sb_idle_busy", 32'(s_busy), 0);

    // Backpressure: 8 samples of 1 with out_ready low
    for (int t = 0; t < 13; t++) begin
      cyc(t < 8, 16'd1, 16'd1, 16'd0, 0, 0);
      if (t == 9) begin
        chk("bp_first_valid", 32'(s_ov), 1);
        chk("bp_first_sum", 32'(s_sum), 4);
        chk("bp_no_overrun_yet", 32'(s_ovr), 0);
      end
      if (t == 12) begin
        chk("bp_held_valid", 32'(s_ov), 1);
        chk("bp_held_sum", 32'(s_sum), 4);
        chk("bp_overrun", 32'(s_ovr), 1);
      end
    end
    cyc(0, 0, 0, 0, 0, 1);
    chk("bp_accept_cycle_valid", 32'(s_ov), 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("bp_after_accept_valid", 32'(s_ov), 0);
    chk("bp_overrun_sticky", 32'(s_ovr), 1);

    // Asynchronous reset mid-frame with a held output
    for (int t = 0; t < 9; t++) cyc(t < 6, 16'd1, 16'd1, 16'd0, 0, 0);
    chk("amid_pre_valid", 32'(out_valid), 1);
    chk("amid_pre_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("amid_out_valid", 32'(out_valid), 0);
    chk("amid_sum", 32'(sum), 0);
    chk("amid_overrun", 32'(overrun), 0);
    chk("amid_busy", 32'(busy), 0);
    cyc(0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 1);
    chk("amid_rel_valid", 32'(s_ov), 0);

    // Accept and completion on the same edge
    for (int t = 0; t < 12; t++) begin
      if (t < 4)      cyc(1, 16'd5, 16'd1, 16'd0, 0, 0);
      else if (t < 8) cyc(1, 16'd3, 16'd3, 16'd0, 0, 0);
      else            cyc(0, 0, 0, 0, 0, t == 10);
      if (t == 9) begin
        chk("simul_first_valid", 32'(s_ov), 1);
        chk("simul_first_sum", 32'(s_sum), 20);
      end
      if (t == 11) begin
        chk("simul_second_valid", 32'(s_ov), 1);
        chk("simul_second_sum", 32'(s_sum), 36);
        chk("simul_overrun", 32'(s_ovr), 0);
      end
    end
    repeat (2) cyc(0, 0, 0, 0, 0, 1);
    chk("simul_drained", 32'(s_ov), 0);

    // Clear with two samples accumulated and one in flight
    for (int t = 0; t < 16; t++) begin
      if (t < 3)                 cyc(1, 16'd100, 16'd1, 16'd0, 0, 1);
      else if (t >= 7 && t < 11) cyc(1, 16'd5, 16'd1, 16'd0, 0, 1);
      else                       cyc(0, 0, 0, 0, t == 5, 1);
      if (t == 4) chk("clr_pre_busy", 32'(s_busy), 1);
      if (t == 6) begin
        chk("clr_busy", 32'(s_busy), 0);
        chk("clr_sum_zero", 32'(s_sum), 0);
        chk("clr_out_valid", 32'(s_ov), 0);
      end
      if (t == 13) chk("clr_no_early_out", 32'(s_ov), 0);
      if (t == 14) begin
        chk("clr_frame_valid", 32'(s_ov), 1);
        chk("clr_frame_sum", 32'(s_sum), 20);
      end
    end

    // Clear coincident with a completion and with a new in_valid
    for (int t = 0; t < 17; t++) begin
      if (t < 4)                 cyc(1, 16'd5, 16'd1, 16'd0, 0, 1);
      else if (t == 6)           cyc(1, 16'd1000, 16'd1, 16'd0, 1, 1);
      else if (t >= 8 && t < 12) cyc(1, 16'd5, 16'd1, 16'd0, 0, 1);
      else                       cyc(0, 0, 0, 0, 0, 1);
      if (t == 7) begin
        chk("clrwin_out_valid", 32'(s_ov), 0);
        chk("clrwin_sum", 32'(s_sum), 0);
        chk("clrwin_busy", 32'(s_busy), 0);
      end
      if (t == 14) chk("clrwin_no_early_out", 32'(s_ov), 0);
      if (t == 15) begin
        chk("clrwin_frame_valid", 32'(s_ov), 1);
        chk("clrwin_frame_sum", 32'(s_sum), 20);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
